prbs23_checker: RTL and testbench
=================================

Name: prbs23_checker

Overview:
- Receive-side partner of the 23-bit XNOR PRBS generator (polynomial x^23 + x^18 + 1).
- Consumes the serial PRBS bit stream, self-synchronises, then compares every later bit against its own local prediction.
- Reports lock, errors and the sequence-start marker, so board-level links and BIST loops can measure bit errors against the generator.

Parameters:
- SEED, 23'h7FFFC5, generator seed (23'h2 XNOR 23'h38); used for the sequence-start marker.
- LOCK_MATCHES, 32, consecutive correct predictions in VERIFY required to enter LOCKED.
- WINDOW_LEN, 1024, valid bits per loss-of-lock observation window.
- LOSS_THRESH, 16, errors within one window that force LOCKED -> SEARCH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bit_in  in  1  received PRBS bit.
- bit_valid  in  1  qualifies bit_in; one bit per asserted cycle.
- clear_cnt  in  1  synchronous clear of err_count and sticky flags.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  16  saturating error count while LOCKED.
- seq_tick  out  1  one-cycle pulse when the local state equals SEED while LOCKED.
- lock_lost  out  1  sticky; set on LOCKED -> SEARCH; cleared by clear_cnt.

Behaviour:
- Stream convention:
  - The transmitted bit is the generator feedback bit, ~(Q[22]^Q[17]), i.e. the new LSB after each shift.
  - Local register r[22:0] holds history; r[0] is the newest bit.
  - Prediction: p = ~(r[22]^r[17]).
  - Shift: r <= {r[21:0], x}.
- The FSM advances only on bit_valid. All outputs are registered and respond on the cycle after the qualifying bit_valid.
- Reset (reset_n low, asynchronous): state = SEARCH, r = 0, all counters 0, all outputs 0.
- SEARCH:
  - Shift in bit_in; fill counter increments.
  - After 23 valid bits, go to VERIFY with match count 0.
- VERIFY:
  - Shift in bit_in.
  - bit_in == p: match count +1. Reaching LOCK_MATCHES goes to LOCKED; locked rises next cycle.
  - Mismatch: match count cleared; stay in VERIFY (register stays self-synchronising).
  - If r becomes all-ones (XNOR lock-up state), go to SEARCH with fill counter 0.
- LOCKED:
  - Shift in p, not bit_in (free-running reference), so one channel error counts exactly once.
  - Mismatch: err_pulse = 1; err_count +1, saturating at 16'hFFFF.
  - Window counter counts valid bits 0..WINDOW_LEN-1, then wraps and clears the window error count.
  - If window errors reach LOSS_THRESH: go to SEARCH, set lock_lost, drop locked next cycle, clear fill/match/window counters. err_count is retained.
  - seq_tick pulses when the post-shift r equals SEED.
- clear_cnt clears err_count and lock_lost; it does not affect FSM state or r.
  - If clear_cnt coincides with an error: the clear wins, err_count = 0 and the error is lost; err_pulse still fires.
- bit_valid low: state, r and counters hold; pulse outputs are 0.

Optional Feature:
- Macro: PRBS23_CHK_BITCNT_EN.
- Defined:
  - Adds output bit_count[31:0]: valid bits compared while LOCKED, saturating.
  - Cleared by clear_cnt and reset; enables BER = err_count/bit_count.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package prbs23_pkg contains:
  - width 23 and tap indices 22/17;
  - default SEED 23'h7FFFC5;
  - state enum {SEARCH, VERIFY, LOCKED};
  - a prbs23_next function (prediction bit).
- Sub-module prbs23_loss_monitor: window counter plus window error counter; outputs loss request. Everything else stays in the top.

Test Plan:
- Generator stream from SEED, bit_valid always high -> locked rises the cycle after valid bit 55 (23 + 32); err_count = 0 over 10000 bits.
- Locked, then flip exactly 1 bit -> one err_pulse, err_count = 1, locked stays high.
- Locked, flip 16 bits inside one 1024-bit window -> lock_lost = 1, locked = 0. Clean stream resumes -> relock after 55 bits; err_count = 16.
- Locked for a full period (8388607 bits) -> seq_tick pulses exactly once per period, aligned with the generator's max-tick.
- All-ones input stream -> never locked, FSM repeatedly returns to SEARCH. reset_n low mid-LOCKED -> all outputs 0 immediately.
- bit_valid toggled at 50% with clean stream -> lock after 55 valid bits. clear_cnt coincident with an error -> err_count = 0.

Source files
------------

// File: rtl/prbs23_pkg.sv
// Shared constants, FSM state type and prediction helper for the PRBS-23 (x^23 + x^18 + 1, XNOR) checker.
package prbs23_pkg;

   localparam int unsigned PRBS_W = 23;
   localparam int unsigned TAP_HI = 22;
   localparam int unsigned TAP_LO = 17;
   localparam logic [PRBS_W-1:0] PRBS23_SEED = 23'h7FFFC5;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

   function automatic logic prbs23_next(input logic [PRBS_W-1:0] r);
      return ~(r[TAP_HI] ^ r[TAP_LO]);
   endfunction

endpackage

// File: rtl/prbs23_loss_monitor.sv
// Loss-of-lock window: counts valid LOCKED bits per window and requests SEARCH once window errors reach the threshold.
module prbs23_loss_monitor #(
   parameter int unsigned WINDOW_LEN  = 1024,
   parameter int unsigned LOSS_THRESH = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic err,
   output logic loss_req
);

   localparam int unsigned WCW = $clog2(WINDOW_LEN);
   localparam int unsigned ECW = $clog2(LOSS_THRESH + 1);
   localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_LEN - 1);
   localparam logic [ECW-1:0] THRESH   = ECW'(LOSS_THRESH);

   logic [WCW-1:0] win_cnt_q, win_cnt_d;
   logic [ECW-1:0] win_err_q, win_err_d;
   logic [ECW-1:0] err_sum;

   always_comb begin
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      loss_req  = 1'b0;
      err_sum   = win_err_q + {{(ECW-1){1'b0}}, err};
      if (en) begin
         // The error on the final bit of a window still counts toward that window.
         if (err_sum == THRESH) begin
            loss_req  = 1'b1;
            win_cnt_d = '0;
            win_err_d = '0;
         end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
         end else begin
            win_cnt_d = win_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
            win_err_d = err_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt_q <= '0;
         win_err_q <= '0;
      end else begin
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
      end
   end

endmodule

// File: rtl/prbs23_checker.sv
// Self-synchronising PRBS-23 XNOR stream checker with lock, error and sequence-start reporting.
// Optional PRBS23_CHK_BITCNT_EN adds a saturating count of bits compared while locked.
module prbs23_checker
   import prbs23_pkg::*;
#(
   parameter logic [PRBS_W-1:0] SEED         = PRBS23_SEED,
   parameter int unsigned       LOCK_MATCHES = 32,
   parameter int unsigned       WINDOW_LEN   = 1024,
   parameter int unsigned       LOSS_THRESH  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        clear_cnt,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic        seq_tick,
   output logic        lock_lost
`ifdef PRBS23_CHK_BITCNT_EN
   ,output logic [31:0] bit_count
`endif
);

   localparam int unsigned     MCW        = $clog2(LOCK_MATCHES + 1);
   localparam logic [MCW-1:0]  MATCH_LAST = MCW'(LOCK_MATCHES - 1);
   localparam logic [4:0]      FILL_LAST  = 5'(PRBS_W - 1);

   prbs_state_e        state_q, state_d;
   logic [PRBS_W-1:0]  r_q, r_d;
   logic [4:0]         fill_q, fill_d;
   logic [MCW-1:0]     match_q, match_d;
   logic [15:0]        err_count_q, err_count_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic               seq_tick_q, seq_tick_d;
   logic               lock_lost_q, lock_lost_d;
   logic               pred;
   logic               mon_en;
   logic               mon_err;
   logic               loss_req;
`ifdef PRBS23_CHK_BITCNT_EN
   logic [31:0]        bit_count_q, bit_count_d;
`endif

   assign pred    = prbs23_next(r_q);
   assign mon_en  = bit_valid && (state_q == LOCKED);
   assign mon_err = (bit_in != pred);

   prbs23_loss_monitor #(
      .WINDOW_LEN  (WINDOW_LEN),
      .LOSS_THRESH (LOSS_THRESH)
   ) u_loss_monitor (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (mon_en),
      .err      (mon_err),
      .loss_req (loss_req)
   );

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      fill_d      = fill_q;
      match_d     = match_q;
      err_count_d = err_count_q;
      lock_lost_d = lock_lost_q;
      err_pulse_d = 1'b0;
      seq_tick_d  = 1'b0;
`ifdef PRBS23_CHK_BITCNT_EN
      bit_count_d = bit_count_q;
`endif
      if (bit_valid) begin
         case (state_q)
            SEARCH: begin
               r_d = {r_q[PRBS_W-2:0], bit_in};
               if (fill_q == FILL_LAST) begin
                  state_d = VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end
            VERIFY: begin
               r_d = {r_q[PRBS_W-2:0], bit_in};
               // All-ones predicts itself forever, so it must abort before any match is credited.
               if (&r_d) begin
                  state_d = SEARCH;
                  fill_d  = '0;
                  match_d = '0;
               end else if (bit_in == pred) begin
                  if (match_q == MATCH_LAST) begin
                     state_d = LOCKED;
                     match_d = '0;
                  end else begin
                     match_d = match_q + {{(MCW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               r_d        = {r_q[PRBS_W-2:0], pred};
               seq_tick_d = (r_d == SEED);
               if (mon_err) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
               end
`ifdef PRBS23_CHK_BITCNT_EN
               if (bit_count_q != '1) bit_count_d = bit_count_q + 32'd1;
`endif
               if (loss_req) begin
                  state_d     = SEARCH;
                  lock_lost_d = 1'b1;
                  fill_d      = '0;
                  match_d     = '0;
               end
            end
            default: begin
               state_d = SEARCH;
               fill_d  = '0;
               match_d = '0;
            end
         endcase
      end
      if (clear_cnt) begin
         err_count_d = '0;
         lock_lost_d = 1'b0;
`ifdef PRBS23_CHK_BITCNT_EN
         bit_count_d = '0;
`endif
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SEARCH;
         r_q         <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         seq_tick_q  <= 1'b0;
         lock_lost_q <= 1'b0;
`ifdef PRBS23_CHK_BITCNT_EN
         bit_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         seq_tick_q  <= seq_tick_d;
         lock_lost_q <= lock_lost_d;
`ifdef PRBS23_CHK_BITCNT_EN
         bit_count_q <= bit_count_d;
`endif
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign seq_tick  = seq_tick_q;
   assign lock_lost = lock_lost_q;
`ifdef PRBS23_CHK_BITCNT_EN
   assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs23_checker.sv
// Bench for prbs23_checker: directed lock/error/loss scenarios plus randomized stream against a queue-based model.
module tb_prbs23_checker;

   localparam logic [22:0] SEED  = 23'h7FFFC5;
   localparam int          LOCKN = 32;
   localparam int          WIN   = 1024;
   localparam int          THR   = 16;

   logic        clk = 1'b0;
   logic        reset_n, bit_in, bit_valid, clear_cnt;
   logic        locked, err_pulse, seq_tick, lock_lost;
   logic [15:0] err_count;
`ifdef PRBS23_CHK_BITCNT_EN
   logic [31:0] bit_count;
`endif

   always #5 clk = ~clk;

   prbs23_checker #(
      .SEED         (SEED),
      .LOCK_MATCHES (LOCKN),
      .WINDOW_LEN   (WIN),
      .LOSS_THRESH  (THR)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .seq_tick  (seq_tick),
      .lock_lost (lock_lost)
`ifdef PRBS23_CHK_BITCNT_EN
      ,.bit_count (bit_count)
`endif
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // expected outputs
   bit     e_locked, e_pulse, e_tick, e_lost;
   int     e_cnt;
   longint e_bc;

   // model: phase 0 = search, 1 = verify, 2 = locked; hist[0] is newest bit
   int m_ph, m_fill, m_match, m_wpos, m_werr;
   bit hist[$];
   int vcount, m_lock_vidx;

   logic [22:0] g;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic gen_bit();
      g = {g[21:0], ~(g[22] ^ g[17])};
      return g[0];
   endfunction

   function automatic logic [22:0] gen_back(input logic [22:0] q);
      return {~q[0] ^ q[18], q[22:1]};
   endfunction

   function automatic logic [22:0] hist_val();
      logic [22:0] v;
      for (int i = 0; i < 23; i++) v[i] = hist[i];
      return v;
   endfunction

   task automatic push(input bit x);
      hist.push_front(x);
      void'(hist.pop_back());
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (23) hist.push_back(1'b0);
      m_ph = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
      vcount = 0; m_lock_vidx = -1;
      e_locked = 0; e_pulse = 0; e_tick = 0; e_lost = 0; e_cnt = 0; e_bc = 0;
   endtask

   task automatic model_step(input bit b, input bit v, input bit c);
      bit p, e;
      e_pulse = 0;
      e_tick  = 0;
      if (v) begin
         p = !(hist[22] ^ hist[17]);
         case (m_ph)
            0: begin
               push(b);
               m_fill++;
               if (m_fill == 23) begin m_ph = 1; m_match = 0; end
            end
            1: begin
               push(b);
               if (hist_val() == 23'h7FFFFF) begin
                  m_ph = 0; m_fill = 0;
               end else if (b == p) begin
                  m_match++;
                  if (m_match == LOCKN) begin m_ph = 2; m_wpos = 0; m_werr = 0; end
               end else begin
                  m_match = 0;
               end
            end
            default: begin
               push(p);
               e = (b != p);
               if (hist_val() == SEED) e_tick = 1;
               if (e_bc < 64'hFFFF_FFFF) e_bc++;
               if (e) begin
                  e_pulse = 1;
                  if (e_cnt < 65535) e_cnt++;
               end
               m_werr += int'(e);
               if (m_werr == THR) begin
                  m_ph = 0; m_fill = 0; m_match = 0; e_lost = 1;
               end else begin
                  m_wpos++;
                  if (m_wpos == WIN) begin m_wpos = 0; m_werr = 0; end
               end
            end
         endcase
      end
      if (c) begin e_cnt = 0; e_lost = 0; e_bc = 0; end
      e_locked = (m_ph == 2);
   endtask

   task automatic drive(input bit b, input bit v, input bit c);
      int prev;
      bit_in = b; bit_valid = v; clear_cnt = c;
      @(posedge clk);
      prev = m_ph;
      if (v) vcount++;
      model_step(b, v, c);
      if (prev != 2 && m_ph == 2 && m_lock_vidx < 0) m_lock_vidx = vcount;
      @(negedge clk);
   endtask

   task automatic do_reset();
      chk_en  = 0;
      reset_n = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1;
      model_reset();
      chk_en = 1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("locked",    32'(locked),    32'(e_locked));
         check("err_pulse", 32'(err_pulse), 32'(e_pulse));
         check("err_count", 32'(err_count), 32'(e_cnt));
         check("seq_tick",  32'(seq_tick),  32'(e_tick));
         check("lock_lost", 32'(lock_lost), 32'(e_lost));
`ifdef PRBS23_CHK_BITCNT_EN
         check("bit_count", bit_count,      32'(e_bc));
`endif
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int dut_lock, ticks, tick_idx, base, relock, lock_cycles;
      logic [22:0] tick_g;
      bit b, v, c;

      reset_n = 0; bit_in = 0; bit_valid = 0; clear_cnt = 0;
      g = SEED;
      for (int i = 0; i < 300; i++) g = gen_back(g);
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_locked",    32'(locked),    32'd0);
      check("rst_err_pulse", 32'(err_pulse), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_seq_tick",  32'(seq_tick),  32'd0);
      check("rst_lock_lost", 32'(lock_lost), 32'd0);
      reset_n = 1;
      chk_en  = 1;

      // clean stream; SEED recurs after bit 300
      dut_lock = -1; ticks = 0; tick_idx = -1; tick_g = '0;
      for (int i = 0; i < 10000; i++) begin
         drive(gen_bit(), 1'b1, 1'b0);
         if (locked && dut_lock < 0) dut_lock = vcount;
         if (seq_tick) begin ticks++; tick_idx = vcount; tick_g = g; end
      end
      check("lock_idx",       32'(dut_lock),    32'd55);
      check("model_lock_idx", 32'(m_lock_vidx), 32'd55);
      check("clean_err_cnt",  32'(err_count),   32'd0);
      check("tick_count",     32'(ticks),       32'd1);
      check("tick_idx",       32'(tick_idx),    32'd300);
      check("tick_gen_state", 32'(tick_g),      32'(SEED));

      // single flipped bit
      drive(~gen_bit(), 1'b1, 1'b0);
      check("flip1_pulse",  32'(err_pulse), 32'd1);
      check("flip1_count",  32'(err_count), 32'd1);
      check("flip1_locked", 32'(locked),    32'd1);
      for (int i = 0; i < 10; i++) drive(gen_bit(), 1'b1, 1'b0);
      check("flip1_hold", 32'(err_count), 32'd1);

      // asynchronous reset while locked
      chk_en = 0;
      #2 reset_n = 0;
      #1;
      check("async_locked",    32'(locked),    32'd0);
      check("async_err_count", 32'(err_count), 32'd0);
      check("async_err_pulse", 32'(err_pulse), 32'd0);
      check("async_seq_tick",  32'(seq_tick),  32'd0);
      check("async_lock_lost", 32'(lock_lost), 32'd0);
      @(negedge clk);
      reset_n = 1;
      model_reset();
      chk_en = 1;

      // relock, then 16 errors inside one window
      for (int i = 0; i < 75; i++) drive(gen_bit(), 1'b1, 1'b0);
      check("pre_loss_locked", 32'(locked), 32'd1);
      for (int i = 0; i < 32; i++) begin
         b = gen_bit();
         drive((i % 2 == 1) ? ~b : b, 1'b1, 1'b0);
      end
      check("loss_lost",   32'(lock_lost), 32'd1);
      check("loss_locked", 32'(locked),    32'd0);
      check("loss_count",  32'(err_count), 32'd16);
      base = vcount; relock = -1;
      for (int i = 0; i < 200; i++) begin
         drive(gen_bit(), 1'b1, 1'b0);
         if (locked && relock < 0) relock = vcount - base;
      end
      check("relock_idx",   32'(relock),    32'd55);
      check("relock_count", 32'(err_count), 32'd16);

      // clear coincident with an error
      drive(~gen_bit(), 1'b1, 1'b1);
      check("clr_err_pulse", 32'(err_pulse), 32'd1);
      check("clr_err_count", 32'(err_count), 32'd0);
      check("clr_lock_lost", 32'(lock_lost), 32'd0);

      // all-ones input never locks
      do_reset();
      lock_cycles = 0;
      for (int i = 0; i < 600; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         if (locked) lock_cycles++;
      end
      check("ones_never_lock", 32'(lock_cycles), 32'd0);

      // 50% bit_valid
      do_reset();
      relock = -1;
      for (int i = 0; i < 400; i++) begin
         v = 1'($urandom_range(0, 1));
         b = v ? gen_bit() : 1'($urandom_range(0, 1));
         drive(b, v, 1'b0);
         if (locked && relock < 0) relock = vcount;
      end
      check("half_valid_lock_idx", 32'(relock), 32'd55);

      // randomized stream with bursty error rates and occasional clears
      for (int blk = 0; blk < 10; blk++) begin
         for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            b = v ? gen_bit() : 1'($urandom_range(0, 1));
            if (v && ($urandom_range(0, (blk % 2 == 1) ? 63 : 511) == 0)) b = ~b;
            c = ($urandom_range(0, 499) == 0);
            drive(b, v, c);
         end
      end

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
